// File: rtl/svc_axi_sram_wr.sv
// AXI4 write-burst to SRAM word-command bridge, one burst in flight; W->SRAM pass-through (0 added latency), N-beat burst = N+2 cycles.
// Backpressure: sram_cmd_ready drives s_axi_wready directly; the B response is held until s_axi_bready.
module svc_axi_sram_wr #(
  parameter int AXI_ADDR_WIDTH = 8,
  parameter int AXI_DATA_WIDTH = 16,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
  parameter int AXI_ID_WIDTH   = 4,
  localparam int O_WIDTH         = $clog2(AXI_STRB_WIDTH),
  localparam int SRAM_ADDR_WIDTH = AXI_ADDR_WIDTH - O_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_axi_awvalid,
  input  logic [AXI_ADDR_WIDTH-1:0]  s_axi_awaddr,
  input  logic [AXI_ID_WIDTH-1:0]    s_axi_awid,
  input  logic [7:0]                 s_axi_awlen,
  input  logic [2:0]                 s_axi_awsize,
  input  logic [1:0]                 s_axi_awburst,
  output logic                       s_axi_awready,
  input  logic                       s_axi_wvalid,
  input  logic [AXI_DATA_WIDTH-1:0]  s_axi_wdata,
  input  logic [AXI_STRB_WIDTH-1:0]  s_axi_wstrb,
  input  logic                       s_axi_wlast,
  output logic                       s_axi_wready,
  output logic                       s_axi_bvalid,
  output logic [AXI_ID_WIDTH-1:0]    s_axi_bid,
  output logic [1:0]                 s_axi_bresp,
  input  logic                       s_axi_bready,
  output logic                       sram_cmd_valid,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_cmd_addr,
  output logic [AXI_DATA_WIDTH-1:0]  sram_cmd_wr_data,
  output logic [AXI_STRB_WIDTH-1:0]  sram_cmd_wr_mask,
  input  logic                       sram_cmd_ready
);

  localparam logic [AXI_ADDR_WIDTH-1:0] LOW_MASK = AXI_ADDR_WIDTH'((1 << O_WIDTH) - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [SRAM_ADDR_WIDTH-1:0] r_addr;
  logic [AXI_ID_WIDTH-1:0]    r_id;
  logic [7:0]                 r_len;
  logic [7:0]                 r_beat;
  logic [1:0]                 r_burst;
  logic                       r_err;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_last_beat;
  logic w_aw_err;

  assign w_aw_hs     = s_axi_awvalid && s_axi_awready;
  assign w_w_hs      = s_axi_wvalid && s_axi_wready;
  assign w_last_beat = (r_beat == r_len);
  // Unsupported size, unaligned start or reserved burst type poison the response but not the writes.
  assign w_aw_err    = (s_axi_awsize != 3'(O_WIDTH)) || ((s_axi_awaddr & LOW_MASK) != '0) ||
                       (s_axi_awburst == 2'b11);

  assign s_axi_bid        = r_id;
  assign s_axi_bresp      = r_err ? 2'b10 : 2'b00;
  assign sram_cmd_addr    = r_addr;
  assign sram_cmd_wr_data = s_axi_wdata;
  assign sram_cmd_wr_mask = s_axi_wstrb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Outputs are gated by rst so nothing is offered or accepted in a reset cycle.
  always_comb begin
    w_state_next   = r_state;
    s_axi_awready  = 1'b0;
    s_axi_wready   = 1'b0;
    sram_cmd_valid = 1'b0;
    s_axi_bvalid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        s_axi_awready = !rst;
        if (s_axi_awvalid) w_state_next = S_DATA;
      end
      S_DATA: begin
        s_axi_wready   = sram_cmd_ready && !rst;
        sram_cmd_valid = s_axi_wvalid && !rst;
        if (w_w_hs && w_last_beat) w_state_next = S_RESP;
      end
      S_RESP: begin
        s_axi_bvalid = !rst;
        if (s_axi_bready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat <= 8'd0;
      r_err  <= 1'b0;
    end else if (w_aw_hs) begin
      r_id    <= s_axi_awid;
      r_len   <= s_axi_awlen;
      r_burst <= s_axi_awburst;
      r_addr  <= s_axi_awaddr[AXI_ADDR_WIDTH-1:O_WIDTH];
      r_beat  <= 8'd0;
      r_err   <= w_aw_err;
    end else if (w_w_hs) begin
      r_beat <= r_beat + 8'd1;
      if (r_burst != 2'b00) r_addr <= r_addr + 1'b1;
      // Beat count, not wlast, ends the burst; a misplaced wlast only flags the response.
      if (s_axi_wlast != w_last_beat) r_err <= 1'b1;
    end
  end

endmodule
